// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute,
// memory and writeback over a shared memory port and a single ALU.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W    = 3,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero_flag,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic                  reg_write,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state;
    state_t state_next;

    logic       ready;
    logic       is_lw;
    logic       is_sw;
    logic       is_r;
    logic       is_i;
    logic       is_br;
    logic       is_jal;
    logic       is_lui;
    logic       br_ok;
    logic       br_take;
    logic [2:0] funct_op;
    logic [2:0] alu_op;

    assign ready  = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign is_lw  = (opcode == 7'b0000011);
    assign is_sw  = (opcode == 7'b0100011);
    assign is_r   = (opcode == 7'b0110011);
    assign is_i   = (opcode == 7'b0010011);
    assign is_br  = (opcode == 7'b1100011);
    assign is_jal = (opcode == 7'b1101111);
    assign is_lui = (opcode == 7'b0110111);

    // Only beq and bne are implemented; other branch kinds trap.
    assign br_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign br_take = ((funct3 == 3'b000) && zero_flag)
                  || ((funct3 == 3'b001) && !zero_flag);

    always_comb begin
        funct_op = ALU_ADD;
        unique case (funct3)
            3'b000: funct_op = (opcode[5] && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010: funct_op = ALU_SLT;
            3'b110: funct_op = ALU_OR;
            3'b111: funct_op = ALU_AND;
            default: funct_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;

        imm_src = 3'b000;
        if (is_sw) begin
            imm_src = 3'b001;
        end else if (is_br) begin
            imm_src = 3'b010;
        end else if (is_jal) begin
            imm_src = 3'b011;
        end else if (is_lui) begin
            imm_src = 3'b100;
        end

        unique case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (is_lw || is_sw) begin
                    state_next = S_MEMADR;
                end else if (is_r) begin
                    state_next = S_EXECR;
                end else if (is_i) begin
                    state_next = S_EXECI;
                end else if (is_br) begin
                    state_next = S_BRANCH;
                end else if (is_jal) begin
                    state_next = S_JAL;
                end else if (is_lui) begin
                    state_next = S_LUI;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
                if (ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
                if (ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = funct_op;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = funct_op;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = ALU_SUB;
                pc_write   = br_ok && br_take;
                state_next = br_ok ? S_FETCH : S_TRAP;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                state_next = S_ALUWB;
            end
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Architectural enables stay off while reset is held.
        if (rst) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
        end
    end

    assign alu_control = ALU_CTRL_W'(alu_op);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed and random instruction
// streams checked cycle by cycle against a per-instruction model.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic       reg_write;
        logic [2:0] alu_control;
        logic       illegal;
    } ctl_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero_flag;
    logic       mem_ready;
    logic       mem_ready1;

    logic       pc_write0, adr_src0, mem_req0, mem_write0, ir_write0;
    logic [1:0] result_src0, alu_src_a0, alu_src_b0;
    logic [2:0] imm_src0, alu_control0;
    logic       reg_write0, illegal0;

    logic       pc_write1, adr_src1, mem_req1, mem_write1, ir_write1;
    logic [1:0] result_src1, alu_src_a1, alu_src_b1;
    logic [2:0] imm_src1, alu_control1;
    logic       reg_write1, illegal1;

    ctl_t act0;
    ctl_t act1;
    bit   chk1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_HANDSHAKE(1'b1)) u0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .pc_write(pc_write0), .adr_src(adr_src0), .mem_req(mem_req0),
        .mem_write(mem_write0), .ir_write(ir_write0),
        .result_src(result_src0), .alu_src_a(alu_src_a0),
        .alu_src_b(alu_src_b0), .imm_src(imm_src0), .reg_write(reg_write0),
        .alu_control(alu_control0), .illegal(illegal0)
    );

    multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_HANDSHAKE(1'b0)) u1 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero_flag(zero_flag), .mem_ready(mem_ready1),
        .pc_write(pc_write1), .adr_src(adr_src1), .mem_req(mem_req1),
        .mem_write(mem_write1), .ir_write(ir_write1),
        .result_src(result_src1), .alu_src_a(alu_src_a1),
        .alu_src_b(alu_src_b1), .imm_src(imm_src1), .reg_write(reg_write1),
        .alu_control(alu_control1), .illegal(illegal1)
    );

    assign act0 = {pc_write0, adr_src0, mem_req0, mem_write0, ir_write0,
                   result_src0, alu_src_a0, alu_src_b0, imm_src0,
                   reg_write0, alu_control0, illegal0};
    assign act1 = {pc_write1, adr_src1, mem_req1, mem_write1, ir_write1,
                   result_src1, alu_src_a1, alu_src_b1, imm_src1,
                   reg_write1, alu_control1, illegal1};

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == OP_LW || op == OP_I) return 3'd0;
        if (op == OP_SW) return 3'd1;
        if (op == OP_BR) return 3'd2;
        if (op == OP_JAL) return 3'd3;
        if (op == OP_LUI) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] op,
                                          input logic [2:0] f3,
                                          input logic f7);
        if (f3 == 3'd0) return (op[5] && f7) ? 3'd1 : 3'd0;
        if (f3 == 3'd2) return 3'd5;
        if (f3 == 3'd6) return 3'd3;
        if (f3 == 3'd7) return 3'd2;
        return 3'd0;
    endfunction

    function automatic ctl_t base();
        ctl_t c = '0;
        c.imm_src = imm_of(opcode);
        return c;
    endfunction

    function automatic ctl_t fetch_exp(input logic rdy);
        ctl_t c = base();
        c.mem_req    = 1'b1;
        c.alu_src_b  = 2'd2;
        c.result_src = 2'd2;
        c.ir_write   = rdy;
        c.pc_write   = rdy;
        return c;
    endfunction

    task automatic chk(input ctl_t e, input string tag);
        checks++;
        assert (act0 === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act0, e);
        end
        if (chk1) begin
            checks++;
            assert (act1 === e) else begin
                errors++;
                $error("FAIL %s_nohs observed=%h expected=%h", tag, act1, e);
            end
        end
    endtask

    task automatic step(input ctl_t e, input string tag);
        #1;
        chk(e, tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        ctl_t e;
        rst = 1'b1;
        #1;
        e = fetch_exp(1'b0);
        chk(e, "reset_async");
        @(posedge clk);
        @(negedge clk);
        chk(e, "reset_held");
        rst = 1'b0;
    endtask

    task automatic trap_run(input int n, input string tag);
        ctl_t e;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            e = base();
            e.illegal = 1'b1;
            step(e, tag);
        end
        do_reset();
    endtask

    task automatic mem_phase(input ctl_t e, input int waits,
                             input string tag);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            step(e, {tag, "_wait"});
        end
        mem_ready = 1'b1;
        step(e, tag);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z,
                             input int wmax, input int trap_len);
        ctl_t e;
        int   wf;
        int   wm;
        opcode    = op;
        funct3    = f3;
        funct7_5  = f7;
        zero_flag = z;
        wf = (wmax == 0) ? 0 : int'($urandom_range(0, wmax));
        wm = (wmax == 0) ? 0 : int'($urandom_range(0, wmax));
        for (int i = 0; i < wf; i++) begin
            mem_ready = 1'b0;
            step(fetch_exp(1'b0), "fetch_wait");
        end
        mem_ready = 1'b1;
        step(fetch_exp(1'b1), "fetch");
        mem_ready = 1'($urandom);
        e = base();
        e.alu_src_a = 2'd1;
        e.alu_src_b = 2'd1;
        step(e, "decode");
        mem_ready = 1'($urandom);
        e = base();
        if (op == OP_LW || op == OP_SW) begin
            e.alu_src_a = 2'd2;
            e.alu_src_b = 2'd1;
            step(e, "memadr");
            e = base();
            e.adr_src = 1'b1;
            e.mem_req = 1'b1;
            e.mem_write = (op == OP_SW);
            mem_phase(e, wm, (op == OP_SW) ? "memwrite" : "memread");
            if (op == OP_LW) begin
                mem_ready = 1'($urandom);
                e = base();
                e.result_src = 2'd1;
                e.reg_write = 1'b1;
                step(e, "memwb");
            end
        end else if (op == OP_R || op == OP_I || op == OP_JAL
                     || op == OP_LUI) begin
            if (op == OP_JAL) begin
                e.alu_src_a = 2'd1;
                e.alu_src_b = 2'd2;
                e.pc_write = 1'b1;
            end else if (op == OP_LUI) begin
                e.alu_src_a = 2'd3;
                e.alu_src_b = 2'd1;
            end else begin
                e.alu_src_a = 2'd2;
                e.alu_src_b = (op == OP_I) ? 2'd1 : 2'd0;
                e.alu_control = alu_of(op, f3, f7);
            end
            step(e, "exec");
            mem_ready = 1'($urandom);
            e = base();
            e.reg_write = 1'b1;
            step(e, "aluwb");
        end else if (op == OP_BR) begin
            e.alu_src_a = 2'd2;
            e.alu_control = 3'd1;
            e.pc_write = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
            step(e, "branch");
            if (f3 > 3'd1) trap_run(trap_len, "trap_branch");
        end else begin
            trap_run(trap_len, "trap_opcode");
        end
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] ops [7];
        int k;
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI};
        k = int'($urandom_range(0, 15));
        if (k >= 7 && k < 14) k = int'($urandom_range(0, 6));
        if (k == 14) return 7'($urandom) | 7'b0001000;
        if (k == 15) return 7'b1111111;
        return ops[k];
    endfunction

    task automatic rand_instr(input int wmax);
        logic [6:0] op;
        logic [2:0] f3;
        op = rand_op();
        f3 = 3'($urandom);
        if (op == OP_BR && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
        run_instr(op, f3, 1'($urandom), 1'($urandom), wmax, 3);
    endtask

    initial begin
        ctl_t e;
        chk1       = 1'b1;
        rst        = 1'b1;
        opcode     = OP_R;
        funct3     = 3'd0;
        funct7_5   = 1'b0;
        zero_flag  = 1'b0;
        mem_ready  = 1'b0;
        mem_ready1 = 1'b0;
        @(negedge clk);
        chk(fetch_exp(1'b0), "reset_state");
        @(negedge clk);
        rst = 1'b0;

        run_instr(OP_R, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_R, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_I, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr(OP_BR, 3'd0, 1'b0, 1'b1, 0, 0);
        run_instr(OP_BR, 3'd1, 1'b0, 1'b1, 0, 0);
        run_instr(OP_JAL, 3'd5, 1'b0, 1'b0, 0, 0);
        run_instr(OP_LUI, 3'd2, 1'b1, 1'b0, 0, 0);
        run_instr(OP_SW, 3'd2, 1'b0, 1'b0, 0, 0);
        run_instr(OP_LW, 3'd2, 1'b0, 1'b0, 0, 0);
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 10);

        for (int i = 0; i < 60; i++) begin
            mem_ready1 = 1'($urandom);
            rand_instr(0);
        end

        // Only the handshaking instance is checked once waits appear.
        chk1 = 1'b0;

        // lw with three low-ready cycles in the read: 8 cycles total.
        opcode = OP_LW;
        funct3 = 3'd2;
        mem_ready = 1'b1;
        step(fetch_exp(1'b1), "lw_fetch");
        e = base();
        e.alu_src_a = 2'd1;
        e.alu_src_b = 2'd1;
        step(e, "lw_decode");
        e = base();
        e.alu_src_a = 2'd2;
        e.alu_src_b = 2'd1;
        step(e, "lw_memadr");
        e = base();
        e.adr_src = 1'b1;
        e.mem_req = 1'b1;
        mem_phase(e, 3, "lw_memread");
        e = base();
        e.result_src = 2'd1;
        e.reg_write = 1'b1;
        step(e, "lw_memwb");

        // Reset asserted mid-store while the write is stalled.
        opcode = OP_SW;
        mem_ready = 1'b1;
        step(fetch_exp(1'b1), "sw_fetch");
        e = base();
        e.alu_src_a = 2'd1;
        e.alu_src_b = 2'd1;
        step(e, "sw_decode");
        e = base();
        e.alu_src_a = 2'd2;
        e.alu_src_b = 2'd1;
        step(e, "sw_memadr");
        mem_ready = 1'b0;
        e = base();
        e.adr_src = 1'b1;
        e.mem_req = 1'b1;
        e.mem_write = 1'b1;
        step(e, "sw_memwrite_wait");
        #1;
        chk(e, "sw_memwrite_hold");
        #2;
        do_reset();

        for (int i = 0; i < 80; i++) begin
            rand_instr(3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
